nn_input_packer: RTL and testbench
==================================

Name: nn_input_packer

Overview:
- Producer side of the NeuralNetwork input interface.
- Accepts a serial stream of 8-bit grayscale pixels over a valid/ready handshake and converts each pixel to fixed point.
- Packs the converted pixels into the flattened NNin vector, then drives NNvalid to the network.
- Holds the frame stable until the network reports NNoutValid, then re-arms for the next frame.

Parameters:
- NUM_INPUTS, 784, pixels per frame (NN input count).
- DATA_WIDTH, 16, width of each NNin element.
- PIX_SHIFT, 5, left shift applied to each pixel to form the fixed-point value (0xFF -> 0x1FE0).
- CNT_WIDTH, 10, width of the pixel index counter; must satisfy 2^CNT_WIDTH > NUM_INPUTS.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- pix_data  in  8  unsigned pixel value.
- pix_valid  in  1  pix_data/pix_sof valid this cycle.
- pix_sof  in  1  qualifies the first pixel of a frame.
- pix_ready  out  1  packer can accept a pixel.
- NNin  out  NUM_INPUTS*DATA_WIDTH  flattened frame; element k at NNin[k*DATA_WIDTH +: DATA_WIDTH].
- NNvalid  out  1  frame complete and stable; held high until NNoutValid.
- NNoutValid  in  1  network result valid (frame consumed).
- frame_err  out  1  one-cycle pulse when a frame is aborted by an early SOF.
- frame_count  out  16  number of frames presented since reset, wraps at 0xFFFF.

Behaviour:
- Reset (async, high):
  - State is FILL and idx=0.
  - NNin=0, NNvalid=0, pix_ready=0 during reset, frame_err=0, frame_count=0.
  - pix_ready goes high on the first clock edge after reset deasserts.
- Transfer rule: a pixel is accepted on any rising edge where pix_valid && pix_ready. There are no transfers while pix_ready=0. Upstream must hold data while pix_valid=1 and pix_ready=0.
- Conversion:
  - value = zero-extend(pix_data) << PIX_SHIFT.
  - If the shifted value exceeds 2^DATA_WIDTH-1, saturate to all ones.
  - Purely combinational, so there is zero latency between acceptance and the write into NNin.
- States:
  - FILL:
    - pix_ready=1, NNvalid=0.
    - Each accepted pixel writes element idx and increments idx.
    - An accepted pixel with pix_sof=1 when idx!=0 pulses frame_err for one cycle. That pixel is written to element 0 and idx becomes 1; the previous partial frame is discarded. Elements that are not rewritten keep stale values; no clearing is required.
    - pix_sof=1 when idx==0 is normal.
    - pix_sof=0 when idx==0 is accepted as element 0; SOF is advisory only.
    - When the accepted pixel has idx==NUM_INPUTS-1: write it, set idx=0, move to PRESENT. NNvalid=1 and pix_ready=0 from the next cycle.
  - PRESENT:
    - NNvalid=1, pix_ready=0, NNin frozen.
    - On the first edge with NNoutValid=1, increment frame_count and go to FILL. NNvalid=0 and pix_ready=1 from the next cycle.
    - NNoutValid=1 while in FILL is ignored.
- Latency: the last pixel accepted on edge N gives NNvalid=1 after edge N. NNoutValid sampled high on edge M gives pix_ready=1 after edge M. This gives a minimum one-cycle bubble between frames.
- NNin is not cleared between frames; each frame fully overwrites it.
- Reset mid-frame or mid-PRESENT returns immediately to the reset values.
- NNvalid is a level, never a pulse, so a downstream edge detect sees exactly one rising edge per frame.

Decomposition:
- Package nn_pkg:
  - localparams NN_NUM_INPUTS=784, NN_DATA_WIDTH=16.
  - typedef enum logic {FILL, PRESENT} packer_state_t.
  - function pix_to_fixed(pix, shift), containing the saturating shift.
- Sub-module nn_pix_convert: combinational 8-bit to DATA_WIDTH saturating shift, parameterised by DATA_WIDTH and PIX_SHIFT. Reused by the future camera path.
- The packer holds the FSM, idx counter and NNin register array.

Test Plan:
- Reset: assert reset mid-FILL after 100 pixels -> NNin=0, NNvalid=0, frame_count=0 asynchronously. After release, pix_ready=1 next edge and idx restarts at 0.
- Full frame, pix_valid always high, pixel k = k mod 256, SOF on k=0:
  - After 784 accepts, NNvalid=1 and pix_ready=0.
  - NNin[0 +: 16]=0x0000, NNin[1*16 +: 16]=0x0020, NNin[255*16 +: 16]=0x1FE0, NNin[783*16 +: 16]=(783 mod 256)<<5=0x01E0.
- Backpressure/gaps: random pix_valid gaps during FILL -> element order is unchanged and the NNin contents match the gap-free run. While in PRESENT, pixels presented with pix_valid=1 are not accepted, and NNin is unchanged over 50 cycles.
- Release: pulse NNoutValid one cycle in PRESENT -> frame_count=1, NNvalid=0 and pix_ready=1 the next cycle. A second full frame gives frame_count=2 and NNin fully replaced.
- Early SOF: send 10 pixels of 0x11, then pixel 0x22 with SOF -> frame_err pulses once, NNin[0 +: 16]=0x0440. 783 more pixels then complete the frame (NNvalid after 784 total post-SOF pixels).
- Saturation: set PIX_SHIFT=9, DATA_WIDTH=16, pixel 0xFF -> element = 0xFFFF. Pixel 0x7F -> 0xFE00.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network input path.
package nn_pkg;

    localparam int unsigned NN_NUM_INPUTS = 784;
    localparam int unsigned NN_DATA_WIDTH = 16;

    typedef enum logic {FILL, PRESENT} packer_state_t;

    // Saturating pixel-to-fixed conversion at the default element width.
    function automatic logic [NN_DATA_WIDTH-1:0] pix_to_fixed(input logic [7:0] pix,
                                                              input int unsigned shift);
        logic [NN_DATA_WIDTH+7:0] wide;
        if (shift >= NN_DATA_WIDTH) begin
            return (pix == 8'd0) ? '0 : '1;
        end
        wide = {{NN_DATA_WIDTH{1'b0}}, pix} << shift;
        if (|wide[NN_DATA_WIDTH+7:NN_DATA_WIDTH]) begin
            return '1;
        end
        return wide[NN_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/nn_pix_convert.sv
// Combinational 8-bit pixel to fixed-point converter with saturation.
module nn_pix_convert #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PIX_SHIFT  = 5
) (
    input  logic [7:0]            pix,
    output logic [DATA_WIDTH-1:0] fixed
);

    // Wide enough that no pixel bit is lost before the saturation test.
    localparam int unsigned WIDE_W = DATA_WIDTH + 8 + PIX_SHIFT;

    logic [WIDE_W-1:0] wide;
    logic              sat;

    assign wide  = WIDE_W'(pix) << PIX_SHIFT;
    assign sat   = |wide[WIDE_W-1:DATA_WIDTH];
    assign fixed = sat ? '1 : wide[DATA_WIDTH-1:0];

endmodule

// File: rtl/nn_input_packer.sv
// Packs a serial pixel stream into the flattened NNin frame and presents it
// to the network until the network reports its result.
module nn_input_packer
    import nn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = NN_NUM_INPUTS,
    parameter int unsigned DATA_WIDTH = NN_DATA_WIDTH,
    parameter int unsigned PIX_SHIFT  = 5,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [7:0]                       pix_data,
    input  logic                             pix_valid,
    input  logic                             pix_sof,
    output logic                             pix_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] NNin,
    output logic                             NNvalid,
    input  logic                             NNoutValid,
    output logic                             frame_err,
    output logic [15:0]                      frame_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_INPUTS - 1);

    packer_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  wr_idx;
    logic                  ready_q;
    logic                  err_q, err_d;
    logic [15:0]           count_q, count_d;
    logic                  accept;
    logic                  restart;
    logic [DATA_WIDTH-1:0] pix_fixed;
    logic [DATA_WIDTH-1:0] elem_q [NUM_INPUTS];

    nn_pix_convert #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIX_SHIFT  (PIX_SHIFT)
    ) u_convert (
        .pix   (pix_data),
        .fixed (pix_fixed)
    );

    // ready_q is only ever high in FILL, so it alone qualifies a transfer.
    assign accept  = pix_valid && ready_q;
    assign restart = accept && pix_sof && (idx_q != '0);
    assign wr_idx  = restart ? '0 : idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    err_d = restart;
                    if (wr_idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PRESENT;
                    end else begin
                        idx_d = wr_idx + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (NNoutValid) begin
                    count_d = count_q + 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == FILL);
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                if (accept && (wr_idx == CNT_WIDTH'(i))) begin
                    elem_q[i] <= pix_fixed;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
        assign NNin[g*DATA_WIDTH +: DATA_WIDTH] = elem_q[g];
    end

    assign pix_ready   = ready_q;
    assign NNvalid     = (state_q == PRESENT);
    assign frame_err   = err_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_nn_input_packer.sv
// Scoreboard bench for nn_input_packer: default frame instance plus a small
// saturating instance.
module tb_nn_input_packer;

    localparam int unsigned N  = 784;
    localparam int unsigned DW = 16;
    localparam int unsigned SH = 5;
    localparam int unsigned SN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [7:0]        pix_data;
    logic              pix_valid, pix_sof, pix_ready;
    logic [N*DW-1:0]   NNin;
    logic              NNvalid, NNoutValid, frame_err;
    logic [15:0]       frame_count;

    logic [7:0]        s_pix_data;
    logic              s_pix_valid, s_pix_sof, s_pix_ready;
    logic [SN*DW-1:0]  s_NNin;
    logic              s_NNvalid, s_NNoutValid, s_frame_err;
    logic [15:0]       s_frame_count;

    nn_input_packer #(
        .NUM_INPUTS (N),
        .DATA_WIDTH (DW),
        .PIX_SHIFT  (SH),
        .CNT_WIDTH  (10)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_ready   (pix_ready),
        .NNin        (NNin),
        .NNvalid     (NNvalid),
        .NNoutValid  (NNoutValid),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    nn_input_packer #(
        .NUM_INPUTS (SN),
        .DATA_WIDTH (DW),
        .PIX_SHIFT  (9),
        .CNT_WIDTH  (3)
    ) u_sat (
        .clk         (clk),
        .reset       (reset),
        .pix_data    (s_pix_data),
        .pix_valid   (s_pix_valid),
        .pix_sof     (s_pix_sof),
        .pix_ready   (s_pix_ready),
        .NNin        (s_NNin),
        .NNvalid     (s_NNvalid),
        .NNoutValid  (s_NNoutValid),
        .frame_err   (s_frame_err),
        .frame_count (s_frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_frame [N];
    int mdl_idx = 0;

    function automatic logic [15:0] fix(input logic [7:0] p, input int sh);
        logic [63:0] v;
        v = 64'(p) << sh;
        return (v > 64'hFFFF) ? 16'hFFFF : v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends at posedge+1; pushes the expected element on acceptance.
    task automatic send_px(input logic [7:0] d, input logic sof, input int gap);
        int  t;
        logic exp_err, last;
        pix_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        t = 0;
        while (!pix_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!pix_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            pix_valid = 1'b0;
            return;
        end
        exp_err = sof && (mdl_idx != 0);
        if (exp_err) begin
            exp_q.delete();
            mdl_idx = 0;
        end
        exp_q.push_back(fix(d, SH));
        mdl_idx++;
        last = (mdl_idx == int'(N));
        if (last) mdl_idx = 0;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check("frame_err", 32'(frame_err), 32'(exp_err));
        check("nnvalid_step", 32'(NNvalid), 32'(last));
    endtask

    task automatic check_frame();
        int t;
        t = 0;
        while (!NNvalid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("nnvalid", 32'(NNvalid), 32'd1);
        check("pix_ready_present", 32'(pix_ready), 32'd0);
        check("frame_len", 32'(exp_q.size()), 32'(N));
        for (int i = 0; i < int'(N); i++) begin
            exp_frame[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check($sformatf("elem%0d", i), 32'(NNin[i*DW +: DW]), 32'(exp_frame[i]));
        end
    endtask

    task automatic release_frame(input logic [15:0] exp_count);
        NNoutValid = 1'b1;
        @(posedge clk);
        #1;
        NNoutValid = 1'b0;
        check("frame_count", 32'(frame_count), 32'(exp_count));
        check("nnvalid_release", 32'(NNvalid), 32'd0);
        check("pix_ready_release", 32'(pix_ready), 32'd1);
    endtask

    logic [7:0]  s_pix [SN];
    int          t_s;

    initial begin
        reset        = 1'b1;
        pix_data     = '0;
        pix_valid    = 1'b0;
        pix_sof      = 1'b0;
        NNoutValid   = 1'b0;
        s_pix_data   = '0;
        s_pix_valid  = 1'b0;
        s_pix_sof    = 1'b0;
        s_NNoutValid = 1'b0;
        s_pix[0] = 8'hFF; s_pix[1] = 8'h7F; s_pix[2] = 8'h01; s_pix[3] = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        check("rst_nnin", 32'(|NNin), 32'd0);
        check("rst_nnvalid", 32'(NNvalid), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(pix_ready), 32'd1);

        // Partial frame then asynchronous reset.
        for (int k = 0; k < 100; k++) send_px(8'(k + 1), k == 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_nnin", 32'(|NNin), 32'd0);
        check("midrst_nnvalid", 32'(NNvalid), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        check("midrst_ready", 32'(pix_ready), 32'd0);
        exp_q.delete();
        mdl_idx = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_midrst", 32'(pix_ready), 32'd1);

        // Frame 1: gap-free, pixel k = k mod 256.
        for (int k = 0; k < int'(N); k++) send_px(8'(k), k == 0, 0);
        check_frame();
        check("f1_e0", 32'(NNin[0 +: DW]), 32'h0000);
        check("f1_e1", 32'(NNin[1*DW +: DW]), 32'h0020);
        check("f1_e255", 32'(NNin[255*DW +: DW]), 32'h1FE0);
        check("f1_e783", 32'(NNin[783*DW +: DW]), 32'h01E0);

        // Pixels offered while presenting must be ignored.
        pix_data  = 8'hAA;
        pix_valid = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("hold_nnvalid", 32'(NNvalid), 32'd1);
        check("hold_ready", 32'(pix_ready), 32'd0);
        for (int i = 0; i < int'(N); i++)
            check($sformatf("hold_elem%0d", i), 32'(NNin[i*DW +: DW]), 32'(exp_frame[i]));

        release_frame(16'd1);

        // NNoutValid in FILL is ignored.
        NNoutValid = 1'b1;
        @(posedge clk);
        #1;
        NNoutValid = 1'b0;
        check("fill_outvalid_ignored", 32'(frame_count), 32'd1);

        // Frame 2: random gaps, no SOF, different pattern.
        for (int k = 0; k < int'(N); k++) send_px(8'(k * 7 + 3), 1'b0, $urandom_range(0, 2));
        check_frame();
        release_frame(16'd2);

        // Early SOF aborts the partial frame.
        for (int k = 0; k < 10; k++) send_px(8'h11, k == 0, 0);
        send_px(8'h22, 1'b1, 0);
        check("esof_e0", 32'(NNin[0 +: DW]), 32'h0440);
        for (int k = 0; k < int'(N) - 1; k++) send_px(8'(k + 5), 1'b0, k % 3);
        check_frame();
        release_frame(16'd3);

        // Saturating instance: shift 9.
        for (int k = 0; k < int'(SN); k++) begin
            s_pix_data  = s_pix[k];
            s_pix_sof   = (k == 0);
            s_pix_valid = 1'b1;
            t_s = 0;
            while (!s_pix_ready && t_s < 100) begin
                @(posedge clk);
                #1;
                t_s++;
            end
            if (!s_pix_ready) check("sat_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
            s_pix_valid = 1'b0;
            s_pix_sof   = 1'b0;
        end
        check("sat_nnvalid", 32'(s_NNvalid), 32'd1);
        check("sat_e0", 32'(s_NNin[0 +: DW]), 32'hFFFF);
        check("sat_e1", 32'(s_NNin[1*DW +: DW]), 32'hFE00);
        for (int k = 0; k < int'(SN); k++)
            check($sformatf("sat_elem%0d", k), 32'(s_NNin[k*DW +: DW]), 32'(fix(s_pix[k], 9)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
